mem_port_arbiter: RTL and testbench

- Shares one external memory port between instruction fetch and data load/store, for the multi-cycle or FPGA build where instruction and data memory are one physical block.
- Grants one requester at a time.
- Sequences a registered request/ready transaction to memory.
- Returns a completion pulse with read data to the winning requester.
- Aborts hung transactions with an error after a programmable timeout.

---
 rtl/mem_port_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one registered request/ready memory port between instruction fetch and data access.
// Define ARB_RR_EN for round-robin tie breaking; the default build uses fixed data-over-fetch priority.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ready,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic             done_c;
  logic             abort_c;

`ifdef ARB_RR_EN
  // 1 = data was granted last, 0 = fetch
  logic last_grant;
`endif

  // Arbitration, completion and timeout decisions
  always_comb begin
    state_next = state;
    if_gnt     = 1'b0;
    d_gnt      = 1'b0;
    done_c     = 1'b0;
    abort_c    = 1'b0;
    case (state)
      IDLE: begin
`ifdef ARB_RR_EN
        if (d_req && (!if_req || !last_grant)) begin
          d_gnt = 1'b1;
        end else if (if_req) begin
          if_gnt = 1'b1;
        end
`else
        if (d_req) begin
          d_gnt = 1'b1;
        end else if (if_req) begin
          if_gnt = 1'b1;
        end
`endif
        if (d_gnt) begin
          state_next = BUSY_D;
        end else if (if_gnt) begin
          state_next = BUSY_IF;
        end
      end
      BUSY_IF, BUSY_D: begin
        if (m_ready) begin
          done_c     = 1'b1;
          state_next = IDLE;
        end else if ((TIMEOUT_CYC != 0) && (cnt == CNT_LAST)) begin
          abort_c    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Memory-side registers and requester responses
  always_ff @(posedge clk) begin
    if (reset) begin
      m_req     <= 1'b0;
      m_we      <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
      cnt       <= '0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      if_err    <= 1'b0;
      d_rvalid  <= 1'b0;
      d_rdata   <= '0;
      d_err     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if_rvalid <= 1'b0;
      if_err    <= 1'b0;
      d_rvalid  <= 1'b0;
      d_err     <= 1'b0;
      busy      <= (state_next != IDLE);
      if (d_gnt || if_gnt) begin
        m_req   <= 1'b1;
        m_we    <= d_gnt & d_we;
        m_addr  <= d_gnt ? d_addr : if_addr;
        m_wdata <= d_gnt ? d_wdata : '0;
        cnt     <= '0;
      end else if (done_c || abort_c) begin
        m_req <= 1'b0;
        if (state == BUSY_D) begin
          d_rvalid <= 1'b1;
          d_err    <= abort_c;
          d_rdata  <= (abort_c || m_we) ? '0 : m_rdata;
        end else begin
          if_rvalid <= 1'b1;
          if_err    <= abort_c;
          if_rdata  <= abort_c ? '0 : m_rdata;
        end
      end else if (m_req) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

`ifdef ARB_RR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b0;
    end else if (d_gnt) begin
      last_grant <= 1'b1;
    end else if (if_gnt) begin
      last_grant <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by random traffic checked against
// a transaction-level model (grant order, m_req window length, completion data and error).
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 4;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req, if_gnt, if_rvalid, if_err;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          m_req, m_we, m_ready, busy;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;

  int tests = 0;
  int fails = 0;
  bit last_d = 1'b0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rdata(m_rdata), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_gnt(input string tag, input bit w_d);
    chk({tag, "_d_gnt"}, d_gnt, w_d);
    chk({tag, "_if_gnt"}, if_gnt, !w_d);
  endtask

  // Finish a transaction granted in the current cycle with a zero-wait read response
  task automatic complete(input string tag, input bit is_d, input logic [AW-1:0] a,
                          input logic [DW-1:0] rd);
    tick();
    if (is_d) d_req = 1'b0; else if_req = 1'b0;
    chk({tag, "_mreq"}, m_req, 1'b1);
    chk({tag, "_maddr"}, m_addr, a);
    m_ready = 1'b1;
    m_rdata = rd;
    tick();
    m_ready = 1'b0;
    chk({tag, "_d_rvalid"}, d_rvalid, is_d);
    chk({tag, "_if_rvalid"}, if_rvalid, !is_d);
    chk({tag, "_rdata"}, is_d ? d_rdata : if_rdata, rd);
    chk({tag, "_err"}, is_d ? d_err : if_err, 1'b0);
  endtask

  initial begin
    logic [DW-1:0] mem [16];
    bit            active, t_d, t_we, mreq_exp, rv_now, exp_err, w_d, w_if;
    bit            pend_if, pend_d, p_we;
    int            g, k, lat, rv_due;
    logic [AW-1:0] t_addr, p_if_addr, p_d_addr;
    logic [DW-1:0] t_wdata, exp_rd, p_wdata;
    bit            w;

    reset = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    m_ready = 1'b0; m_rdata = '0;
    tick(); tick();
    chk("rst_mreq", m_req, 1'b0);
    chk("rst_mwe", m_we, 1'b0);
    chk("rst_maddr", m_addr, '0);
    chk("rst_mwdata", m_wdata, '0);
    chk("rst_if_rvalid", if_rvalid, 1'b0);
    chk("rst_if_rdata", if_rdata, '0);
    chk("rst_if_err", if_err, 1'b0);
    chk("rst_d_rvalid", d_rvalid, 1'b0);
    chk("rst_d_rdata", d_rdata, '0);
    chk("rst_d_err", d_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b0;
    tick();

    // Single fetch, memory ready on the first m_req cycle
    if_req = 1'b1; if_addr = 32'h10;
    #1 chk_gnt("f1", 1'b0);
    last_d = 1'b0;
    tick();
    if_req = 1'b0;
    chk("f1_mreq", m_req, 1'b1);
    chk("f1_maddr", m_addr, 32'h10);
    chk("f1_mwe", m_we, 1'b0);
    chk("f1_busy", busy, 1'b1);
    m_ready = 1'b1; m_rdata = 32'h0050_0093;
    tick();
    m_ready = 1'b0;
    chk("f1_rvalid", if_rvalid, 1'b1);
    chk("f1_rdata", if_rdata, 32'h0050_0093);
    chk("f1_err", if_err, 1'b0);
    chk("f1_d_rvalid", d_rvalid, 1'b0);
    chk("f1_mreq_low", m_req, 1'b0);
    chk("f1_busy_low", busy, 1'b0);
    tick();
    chk("f1_rvalid_pulse", if_rvalid, 1'b0);

    // Store with three wait cycles; inputs scrambled after grant to test m_* stability
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF;
    #1 chk_gnt("st", 1'b1);
    last_d = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
      chk("st_mreq", m_req, 1'b1);
      chk("st_mwe", m_we, 1'b1);
      chk("st_maddr", m_addr, 32'h200);
      chk("st_mwdata", m_wdata, 32'hDEAD_BEEF);
      m_ready = (i == 3);
      m_rdata = 32'h1234_5678;
    end
    tick();
    m_ready = 1'b0;
    chk("st_rvalid", d_rvalid, 1'b1);
    chk("st_rdata", d_rdata, '0);
    chk("st_err", d_err, 1'b0);
    chk("st_mreq_low", m_req, 1'b0);

    // Simultaneous requests
    if_req = 1'b1; if_addr = 32'h40; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
    w = RR ? !last_d : 1'b1;
    #1 chk_gnt("tie1", w);
    last_d = w;
    complete("tie1", w, w ? 32'h80 : 32'h40, 32'hA1);
    #1 chk_gnt("tie1_loser", !w);
    last_d = !w;
    complete("tie1b", !w, w ? 32'h40 : 32'h80, 32'hB2);
    if_req = 1'b1; d_req = 1'b1;
    w = RR ? !last_d : 1'b1;
    #1 chk_gnt("tie2", w);
    last_d = w;
    complete("tie2", w, w ? 32'h80 : 32'h40, 32'hC3);
    if (w) d_req = 1'b1; else if_req = 1'b1;
    w = RR ? !last_d : 1'b1;
    #1 chk_gnt("tie3", w);
    last_d = w;
    complete("tie3", w, w ? 32'h80 : 32'h40, 32'hD4);
    if_req = 1'b0; d_req = 1'b0;

    // Fetch timeout: memory never ready
    if_req = 1'b1; if_addr = 32'h300;
    #1 chk_gnt("to", 1'b0);
    last_d = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if_req = 1'b0;
      chk("to_mreq", m_req, 1'b1);
    end
    tick();
    chk("to_mreq_low", m_req, 1'b0);
    chk("to_rvalid", if_rvalid, 1'b1);
    chk("to_err", if_err, 1'b1);
    chk("to_rdata", if_rdata, '0);
    chk("to_busy", busy, 1'b0);

    // Ready on the last allowed cycle wins over the timeout
    if_req = 1'b1; if_addr = 32'h304;
    #1 chk_gnt("tr", 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      if_req = 1'b0;
      chk("tr_mreq", m_req, 1'b1);
      m_ready = (i == 3);
      m_rdata = 32'h5A5A_0001;
    end
    tick();
    m_ready = 1'b0;
    chk("tr_rvalid", if_rvalid, 1'b1);
    chk("tr_err", if_err, 1'b0);
    chk("tr_rdata", if_rdata, 32'h5A5A_0001);

    // Reset while a load is in flight drops it silently
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44;
    #1 chk_gnt("rb", 1'b1);
    tick();
    d_req = 1'b0;
    chk("rb_mreq", m_req, 1'b1);
    reset = 1'b1; m_ready = 1'b1; m_rdata = 32'h77;
    tick();
    reset = 1'b0; m_ready = 1'b0;
    chk("rb_mreq_low", m_req, 1'b0);
    chk("rb_maddr", m_addr, '0);
    chk("rb_busy", busy, 1'b0);
    chk("rb_d_rdata", d_rdata, '0);
    chk("rb_if_rdata", if_rdata, '0);
    for (int i = 0; i < 5; i++) begin
      chk("rb_no_d_rvalid", d_rvalid, 1'b0);
      chk("rb_no_if_rvalid", if_rvalid, 1'b0);
      tick();
    end
    last_d = 1'b0;

    // Random traffic against a transaction-level model
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    active = 1'b0; pend_if = 1'b0; pend_d = 1'b0;
    g = 0; k = 0; lat = 0; rv_due = -1; t_d = 1'b0; t_we = 1'b0; exp_err = 1'b0;
    t_addr = '0; t_wdata = '0; exp_rd = '0; p_we = 1'b0; p_wdata = '0;
    p_if_addr = '0; p_d_addr = '0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      mreq_exp = active && (c >= g + 1) && (c <= g + k);
      rv_now = active && (c == rv_due);
      chk("rnd_mreq", m_req, mreq_exp);
      chk("rnd_busy", busy, mreq_exp);
      if (mreq_exp) begin
        chk("rnd_maddr", m_addr, t_addr);
        chk("rnd_mwe", m_we, t_we);
        chk("rnd_mwdata", m_wdata, t_wdata);
      end
      chk("rnd_if_rvalid", if_rvalid, rv_now && !t_d);
      chk("rnd_d_rvalid", d_rvalid, rv_now && t_d);
      if (rv_now) begin
        chk("rnd_err", t_d ? d_err : if_err, exp_err);
        chk("rnd_rdata", t_d ? d_rdata : if_rdata, exp_rd);
        active = 1'b0;
      end

      if (pend_if && ($urandom_range(0, 9) == 0)) pend_if = 1'b0;
      else if (!pend_if && ($urandom_range(0, 2) == 0)) begin
        pend_if = 1'b1;
        p_if_addr = AW'($urandom_range(0, 15)) << 2;
      end
      if (pend_d && ($urandom_range(0, 9) == 0)) pend_d = 1'b0;
      else if (!pend_d && ($urandom_range(0, 2) == 0)) begin
        pend_d = 1'b1;
        p_d_addr = AW'($urandom_range(0, 15)) << 2;
        p_we = $urandom_range(0, 1) == 1;
        p_wdata = $urandom;
      end
      if_req = pend_if; if_addr = p_if_addr;
      d_req = pend_d; d_addr = p_d_addr; d_we = p_we; d_wdata = p_wdata;
      if (mreq_exp) begin
        m_ready = (c == g + 1 + lat);
        m_rdata = m_ready ? mem[t_addr[5:2]] : $urandom;
      end else begin
        m_ready = $urandom_range(0, 1) == 1;
        m_rdata = $urandom;
      end
      #1;

      w_d = 1'b0; w_if = 1'b0;
      if (!mreq_exp) begin
        w_d = pend_d && (!RR || !pend_if || !last_d);
        w_if = pend_if && !w_d;
      end
      chk("rnd_d_gnt", d_gnt, w_d);
      chk("rnd_if_gnt", if_gnt, w_if);
      if (w_d || w_if) begin
        active = 1'b1; g = c; t_d = w_d; last_d = w_d;
        lat = $urandom_range(0, 5);
        k = (lat + 1 <= TO) ? lat + 1 : TO;
        exp_err = (lat + 1 > TO);
        rv_due = g + 1 + k;
        t_addr = w_d ? p_d_addr : p_if_addr;
        t_we = w_d && p_we;
        t_wdata = w_d ? p_wdata : '0;
        exp_rd = (exp_err || t_we) ? '0 : mem[t_addr[5:2]];
        if (t_we && !exp_err) mem[t_addr[5:2]] = t_wdata;
        if (w_d) pend_d = 1'b0; else pend_if = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
